hazard_match_tracker: RTL and testbench

- Producer side of the hazard unit interface for the dual-issue pipeline.
- Carries the register addresses and write enables of both issue slots through the E, M and W stages.
- Compares the E-stage source addresses against the M/W destination addresses and drives Match[7:0], LME and the RegWrite1/2 M/W bits consumed by the hazard unit.
- Takes FlushE back from the hazard unit and applies it to its own E-stage register.

---
 rtl/hazard_match_tracker_pkg.sv | 52 +++++
 rtl/hazard_match_tracker_stage_reg.sv | 23 ++
 rtl/hazard_match_tracker.sv | 114 +++++++++++
 tb/tb_hazard_match_tracker.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_match_tracker_pkg.sv
// Shared types and constants for the hazard-unit producer side: address width,
// PC address and the fixed Match bit positions consumed by the hazard unit.
package hazard_match_tracker_pkg;

    localparam int ADDR_W = 4;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t PC_ADDR = 4'hF;

    // Match bit positions; the W2 pair intentionally lists RA2 above RA1.
    localparam int M1_RA1 = 7;
    localparam int M1_RA2 = 6;
    localparam int W1_RA1 = 5;
    localparam int W1_RA2 = 4;
    localparam int M2_RA1 = 3;
    localparam int M2_RA2 = 2;
    localparam int W2_RA2 = 1;
    localparam int W2_RA1 = 0;

    typedef struct packed {
        addr_t ra1;
        addr_t ra2;
        addr_t wa1;
        addr_t wa2;
        logic  reg_write1;
        logic  reg_write2;
        logic  mem_to_reg1;
        logic  mem_to_reg2;
    } e_stage_t;

    typedef struct packed {
        addr_t wa1;
        addr_t wa2;
        logic  reg_write1;
        logic  reg_write2;
        logic  mem_to_reg1;
        logic  mem_to_reg2;
    } m_stage_t;

    typedef struct packed {
        addr_t wa1;
        addr_t wa2;
        logic  reg_write1;
        logic  reg_write2;
    } w_stage_t;

    function automatic logic src_hit(input addr_t src, input addr_t dst, input logic we);
        return we && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_match_tracker_stage_reg.sv
// hz_stage_reg: generic pipeline stage register with asynchronous active-low
// clear and a synchronous flush that loads a bubble (all zeros).
module hz_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_match_tracker.sv
// Carries both issue slots' register addresses through E/M/W and produces the
// Match vector, LME and stage write enables for the hazard unit.
// Optional build macro: HZ_MATCH_PC_MASK_EN (suppress matches on PC-address sources).
module hazard_match_tracker
    import hazard_match_tracker_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    input  logic [ADDR_W-1:0] WA1D,
    input  logic [ADDR_W-1:0] WA2D,
    input  logic              RegWrite1D,
    input  logic              RegWrite2D,
    input  logic              MemtoReg1D,
    input  logic              MemtoReg2D,
    input  logic              FlushE,
    output logic [7:0]        Match,
    output logic              LME,
    output logic              RegWrite1M,
    output logic              RegWrite1W,
    output logic              RegWrite2M,
    output logic              RegWrite2W
);

    e_stage_t e_d, e_q;
    m_stage_t m_d, m_q;
    w_stage_t w_d, w_q;
    logic [7:0] match_raw;

    always_comb begin
        e_d.ra1         = RA1D;
        e_d.ra2         = RA2D;
        e_d.wa1         = WA1D;
        e_d.wa2         = WA2D;
        e_d.reg_write1  = RegWrite1D;
        e_d.reg_write2  = RegWrite2D;
        e_d.mem_to_reg1 = MemtoReg1D;
        e_d.mem_to_reg2 = MemtoReg2D;

        m_d.wa1         = e_q.wa1;
        m_d.wa2         = e_q.wa2;
        m_d.reg_write1  = e_q.reg_write1;
        m_d.reg_write2  = e_q.reg_write2;
        m_d.mem_to_reg1 = e_q.mem_to_reg1;
        m_d.mem_to_reg2 = e_q.mem_to_reg2;

        w_d.wa1         = m_q.wa1;
        w_d.wa2         = m_q.wa2;
        w_d.reg_write1  = m_q.reg_write1;
        w_d.reg_write2  = m_q.reg_write2;
    end

    // Stalls upstream always come with FlushE, so E never needs a hold path.
    hz_stage_reg #(.W($bits(e_stage_t))) u_stage_e (
        .clk   (clk),
        .reset (reset),
        .flush (FlushE),
        .d     (e_d),
        .q     (e_q)
    );

    hz_stage_reg #(.W($bits(m_stage_t))) u_stage_m (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .d     (m_d),
        .q     (m_q)
    );

    hz_stage_reg #(.W($bits(w_stage_t))) u_stage_w (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .d     (w_d),
        .q     (w_q)
    );

    // Write-enable qualification also hides address-0 hits from bubbles.
    always_comb begin
        match_raw         = '0;
        match_raw[M1_RA1] = src_hit(e_q.ra1, m_q.wa1, m_q.reg_write1);
        match_raw[M1_RA2] = src_hit(e_q.ra2, m_q.wa1, m_q.reg_write1);
        match_raw[W1_RA1] = src_hit(e_q.ra1, w_q.wa1, w_q.reg_write1);
        match_raw[W1_RA2] = src_hit(e_q.ra2, w_q.wa1, w_q.reg_write1);
        match_raw[M2_RA1] = src_hit(e_q.ra1, m_q.wa2, m_q.reg_write2);
        match_raw[M2_RA2] = src_hit(e_q.ra2, m_q.wa2, m_q.reg_write2);
        match_raw[W2_RA2] = src_hit(e_q.ra2, w_q.wa2, w_q.reg_write2);
        match_raw[W2_RA1] = src_hit(e_q.ra1, w_q.wa2, w_q.reg_write2);
`ifdef HZ_MATCH_PC_MASK_EN
        // The PC operand comes from the PC path and is never forwarded.
        if (e_q.ra1 == PC_ADDR) begin
            match_raw[M1_RA1] = 1'b0;
            match_raw[W1_RA1] = 1'b0;
            match_raw[M2_RA1] = 1'b0;
            match_raw[W2_RA1] = 1'b0;
        end
        if (e_q.ra2 == PC_ADDR) begin
            match_raw[M1_RA2] = 1'b0;
            match_raw[W1_RA2] = 1'b0;
            match_raw[M2_RA2] = 1'b0;
            match_raw[W2_RA2] = 1'b0;
        end
`endif
    end

    assign Match      = match_raw;
    assign LME        = (m_q.mem_to_reg1 & m_q.reg_write1) | (m_q.mem_to_reg2 & m_q.reg_write2);
    assign RegWrite1M = m_q.reg_write1;
    assign RegWrite2M = m_q.reg_write2;
    assign RegWrite1W = w_q.reg_write1;
    assign RegWrite2W = w_q.reg_write2;

endmodule

// File: tb/tb_hazard_match_tracker.sv
// Scoreboard bench for hazard_match_tracker: a history-queue reference model
// predicts outputs per clock, a monitor compares them on the falling edge.
module tb_hazard_match_tracker;

    typedef struct packed {
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] wa1;
        logic [3:0] wa2;
        logic       rw1;
        logic       rw2;
        logic       mr1;
        logic       mr2;
    } instr_t;

    typedef struct packed {
        logic [7:0] match;
        logic [4:0] flags;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, WA1D, WA2D;
    logic       RegWrite1D, RegWrite2D, MemtoReg1D, MemtoReg2D, FlushE;
    logic [7:0] Match;
    logic       LME, RegWrite1M, RegWrite1W, RegWrite2M, RegWrite2W;

    int checks   = 0;
    int failures = 0;

    instr_t hist[$];
    exp_t   sb_q[$];

    hazard_match_tracker dut (
        .clk        (clk),
        .reset      (reset),
        .RA1D       (RA1D),
        .RA2D       (RA2D),
        .WA1D       (WA1D),
        .WA2D       (WA2D),
        .RegWrite1D (RegWrite1D),
        .RegWrite2D (RegWrite2D),
        .MemtoReg1D (MemtoReg1D),
        .MemtoReg2D (MemtoReg2D),
        .FlushE     (FlushE),
        .Match      (Match),
        .LME        (LME),
        .RegWrite1M (RegWrite1M),
        .RegWrite1W (RegWrite1W),
        .RegWrite2M (RegWrite2M),
        .RegWrite2W (RegWrite2W)
    );

    always #5 clk = ~clk;

    // A source hits a destination only when that producer writes.
    function automatic logic hit(input logic [3:0] src, input logic [3:0] dst, input logic we);
        logic h;
        h = we && (src == dst);
`ifdef HZ_MATCH_PC_MASK_EN
        if (src == 4'hF) h = 1'b0;
`endif
        return h;
    endfunction

    // hist[0] is the instruction now in E, hist[1] in M, hist[2] in W.
    function automatic exp_t predict();
        exp_t   r;
        instr_t e, m, w;
        e = hist[0];
        m = hist[1];
        w = hist[2];
        r.match[7] = hit(e.ra1, m.wa1, m.rw1);
        r.match[6] = hit(e.ra2, m.wa1, m.rw1);
        r.match[5] = hit(e.ra1, w.wa1, w.rw1);
        r.match[4] = hit(e.ra2, w.wa1, w.rw1);
        r.match[3] = hit(e.ra1, m.wa2, m.rw2);
        r.match[2] = hit(e.ra2, m.wa2, m.rw2);
        r.match[1] = hit(e.ra2, w.wa2, w.rw2);
        r.match[0] = hit(e.ra1, w.wa2, w.rw2);
        r.flags = {(m.mr1 && m.rw1) || (m.mr2 && m.rw2), m.rw1, w.rw1, m.rw2, w.rw2};
        return r;
    endfunction

    function automatic logic [3:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 4'hF;
        return 4'($urandom_range(0, 3));
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.ra1 = rand_addr();
        i.ra2 = rand_addr();
        i.wa1 = rand_addr();
        i.wa2 = rand_addr();
        i.rw1 = 1'($urandom_range(0, 1));
        i.rw2 = 1'($urandom_range(0, 1));
        i.mr1 = 1'($urandom_range(0, 1));
        i.mr2 = 1'($urandom_range(0, 1));
        return i;
    endfunction

    function automatic instr_t mk(input logic [3:0] ra1, input logic [3:0] ra2,
                                  input logic [3:0] wa1, input logic [3:0] wa2,
                                  input logic rw1, input logic rw2,
                                  input logic mr1, input logic mr2);
        instr_t i;
        i.ra1 = ra1; i.ra2 = ra2; i.wa1 = wa1; i.wa2 = wa2;
        i.rw1 = rw1; i.rw2 = rw2; i.mr1 = mr1; i.mr2 = mr2;
        return i;
    endfunction

    task automatic drive(input instr_t ins, input logic flush);
        RA1D = ins.ra1; RA2D = ins.ra2; WA1D = ins.wa1; WA2D = ins.wa2;
        RegWrite1D = ins.rw1; RegWrite2D = ins.rw2;
        MemtoReg1D = ins.mr1; MemtoReg2D = ins.mr2;
        FlushE = flush;
    endtask

    task automatic clear_model();
        hist.delete();
        repeat (3) hist.push_back('0);
    endtask

    // Issue one D-stage instruction and record what the DUT must show after the edge.
    task automatic applyStimulus(input instr_t ins, input logic flush);
        drive(ins, flush);
        @(posedge clk);
        #1;
        hist.push_front(flush ? instr_t'('0) : ins);
        void'(hist.pop_back());
        sb_q.push_back(predict());
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp_match, input logic exp_lme);
        @(negedge clk);
        checks++;
        if (Match !== exp_match || LME !== exp_lme) begin
            failures++;
            $display("[TB] FAIL %s: Match=%h LME=%b, required Match=%h LME=%b",
                     name, Match, LME, exp_match, exp_lme);
        end
    endtask

    // Monitor: pops one prediction per falling edge and compares it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (Match !== e.match) begin
                    failures++;
                    $display("[TB] FAIL sb_match @%0t: got %h, required %h", $time, Match, e.match);
                end
                checks++;
                if ({LME, RegWrite1M, RegWrite1W, RegWrite2M, RegWrite2W} !== e.flags) begin
                    failures++;
                    $display("[TB] FAIL sb_flags @%0t: got %b, required %b (LME,RW1M,RW1W,RW2M,RW2W)",
                             $time, {LME, RegWrite1M, RegWrite1W, RegWrite2M, RegWrite2W}, e.flags);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        instr_t nop;
        instr_t ri;
        nop = '0;

        // Power-on reset with random D inputs.
        reset = 1'b0;
        clear_model();
        drive(rand_instr(), 1'($urandom_range(0, 1)));
        repeat (4) begin
            @(posedge clk);
            #1;
            sb_q.push_back('0);
            drive(rand_instr(), 1'($urandom_range(0, 1)));
        end
        reset = 1'b1;
        checkOutput("reset_hold", 8'h00, 1'b0);
        repeat (3) begin
            ri = rand_instr();
            ri.rw1 = 1'b0;
            ri.rw2 = 1'b0;
            applyStimulus(ri, 1'b0);
        end
        checkOutput("after_release", 8'h00, 1'b0);

        $display("[TB] slot-1 M then W match");
        applyStimulus(mk(0, 0, 3, 0, 1, 0, 0, 0), 1'b0);
        applyStimulus(mk(3, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        checkOutput("m1_ra1", 8'h80, 1'b0);
        applyStimulus(mk(3, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        checkOutput("w1_ra1", 8'h20, 1'b0);

        $display("[TB] slot-2 W match on RA2");
        applyStimulus(mk(0, 0, 0, 5, 0, 1, 0, 0), 1'b0);
        applyStimulus(nop, 1'b0);
        applyStimulus(mk(0, 5, 0, 0, 0, 0, 0, 0), 1'b0);
        checkOutput("w2_ra2", 8'h02, 1'b0);

        $display("[TB] load-use then flush");
        applyStimulus(mk(0, 0, 4, 0, 1, 0, 1, 0), 1'b0);
        applyStimulus(mk(4, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        checkOutput("load_use", 8'h80, 1'b1);
        applyStimulus(mk(4, 4, 0, 0, 0, 0, 0, 0), 1'b1);
        checkOutput("flush_bubble", 8'h00, 1'b0);
        applyStimulus(mk(4, 4, 0, 0, 0, 0, 0, 0), 1'b1);
        checkOutput("flush_again", 8'h00, 1'b0);

        $display("[TB] write-enable qualification");
        applyStimulus(mk(0, 0, 2, 0, 0, 0, 1, 0), 1'b0);
        applyStimulus(mk(2, 2, 0, 0, 0, 0, 0, 0), 1'b0);
        checkOutput("we_masked", 8'h00, 1'b0);

        $display("[TB] PC-address source");
        applyStimulus(mk(0, 0, 15, 0, 1, 0, 0, 0), 1'b0);
        applyStimulus(mk(15, 0, 0, 0, 0, 0, 0, 0), 1'b0);
`ifdef HZ_MATCH_PC_MASK_EN
        checkOutput("pc_src", 8'h00, 1'b0);
`else
        checkOutput("pc_src", 8'h80, 1'b0);
`endif

        $display("[TB] randomized traffic with a mid-run reset");
        for (int n = 0; n < 300; n++) begin
            applyStimulus(rand_instr(), ($urandom_range(0, 4) == 0));
            if (n == 150) begin
                // Reset lands before the next falling edge, so the clear must be asynchronous.
                void'(sb_q.pop_back());
                reset = 1'b0;
                clear_model();
                sb_q.push_back('0);
                repeat (2) begin
                    @(posedge clk);
                    #1;
                    sb_q.push_back('0);
                    drive(rand_instr(), 1'($urandom_range(0, 1)));
                end
                reset = 1'b1;
            end
        end

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d predictions left, required 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
